alu_decode_stage: RTL

- Producer end of the ALU interface: accepts 32-bit RV32I instruction words over valid/ready and decodes OP and OP-IMM instructions.
- Fetches operands from the register file and presents a registered {a, b, control, rd} bundle to the ALU/execute stage over valid/ready.
- Contains a 2-entry skid buffer, so both handshakes are fully registered and back-to-back throughput is 1 instruction/cycle.

---
 rtl/alu_decode_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes RV32I OP / OP-IMM instructions, reads the register
// file and delivers a registered {a, b, control, rd, illegal} bundle to the ALU.
// A two-entry buffer (OUT + SKID) keeps both handshakes registered while
// sustaining one instruction per cycle.
// Optional build macro: ALU_DECODE_LUI_EN (decode LUI as a legal ADD of an upper immediate).
module alu_decode_stage #(
    parameter int unsigned N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [N-1:0]     rs1_data,
    input  logic [N-1:0]     rs2_data,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_control,
    output logic [4:0]       alu_rd,
    output logic             illegal
);

    localparam int unsigned XLEN   = N;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
`ifdef ALU_DECODE_LUI_EN
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
`endif
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    typedef struct packed {
        logic              illegal;
        alu_control_t      ctrl;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [REG_AW-1:0] rd;
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{
        illegal: 1'b0,
        ctrl:    ALU_ADD,
        a:       '0,
        b:       '0,
        rd:      '0
    };

    // Instruction fields
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd_field;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_shamt;
`ifdef ALU_DECODE_LUI_EN
    logic [XLEN-1:0]   imm_u;
`endif
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;

    // Decode outputs
    logic              dec_legal;
    alu_control_t      dec_ctrl;
    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    bundle_t           dec_bundle;

    // Buffer state
    bundle_t out_q,  out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q,   out_valid_d;
    logic    skid_valid_q,  skid_valid_d;
    logic    instr_ready_q, instr_ready_d;

    logic accept;
    logic drain;

    // Field extraction and register-file addressing
    assign opcode    = instr[6:0];
    assign rd_field  = instr[11:7];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];
    assign imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
`ifdef ALU_DECODE_LUI_EN
    assign imm_u     = {instr[31:12], 12'b0};
`endif

    // x0 always reads as zero regardless of what the register file returns
    assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;

    // Instruction decode: control code, operand selection and legality
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_ctrl = ALU_ADD;
                        3'b001:  dec_ctrl = ALU_SLL;
                        3'b010:  dec_ctrl = ALU_SLT;
                        3'b011:  dec_ctrl = ALU_SLTU;
                        3'b100:  dec_ctrl = ALU_XOR;
                        3'b101:  dec_ctrl = ALU_SRL;
                        3'b110:  dec_ctrl = ALU_OR;
                        default: dec_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_SRA;
                    end
                end
            end
            OPC_OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_ctrl = ALU_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_ctrl = ALU_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_ctrl = ALU_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND;  end
                    3'b001: begin
                        dec_b = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SLL;
                        end
                    end
                    default: begin
                        // funct3 101: shift right, funct7 picks logical or arithmetic
                        dec_b = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SRA;
                        end
                    end
                endcase
            end
`ifdef ALU_DECODE_LUI_EN
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_a     = '0;
                dec_b     = imm_u;
            end
`endif
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Bundle assembly; an illegal instruction becomes a harmless ADD 0,0 -> x0
    always_comb begin
        dec_bundle = BUNDLE_RST;
        if (dec_legal) begin
            dec_bundle.illegal = 1'b0;
            dec_bundle.ctrl    = dec_ctrl;
            dec_bundle.a       = dec_a;
            dec_bundle.b       = dec_b;
            dec_bundle.rd      = rd_field;
        end else begin
            dec_bundle.illegal = 1'b1;
        end
    end

    assign accept = instr_valid & instr_ready_q;
    assign drain  = out_valid_q & alu_ready;

    // OUT/SKID steering; SKID only fills while OUT is stalled, and accept is
    // blocked whenever SKID is full so drain-with-skid never collides with accept
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_bundle;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (accept) begin
                out_d       = dec_bundle;
                out_valid_d = 1'b1;
            end
        end else if (accept) begin
            skid_d       = dec_bundle;
            skid_valid_d = 1'b1;
        end
        instr_ready_d = ~skid_valid_d;
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= BUNDLE_RST;
            out_valid_q   <= 1'b0;
            skid_q        <= BUNDLE_RST;
            skid_valid_q  <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
            instr_ready_q <= instr_ready_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_valid   = out_valid_q;
    assign alu_a       = out_q.a;
    assign alu_b       = out_q.b;
    assign alu_control = out_q.ctrl;
    assign alu_rd      = out_q.rd;
    assign illegal     = out_q.illegal;

endmodule
